// File: rtl/ram_word_pkg.sv
// Shared types and constants for the 16-bit word front end of the 8-bit byte RAM.
package ram_word_pkg;

   localparam int BYTE_W        = 8;
   localparam int WORD_W        = 16;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_MEM_DEPTH = 10000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
      ST_CAP  = 3'd3,
      ST_RESP = 3'd4
   } state_t;

endpackage

// File: rtl/ram_word_port.sv
// Word request front end for an 8-bit synchronous RAM: each word becomes two byte accesses, low byte first.
// Optional address range check is enabled by defining RAM_WORD_PORT_ADDR_CHECK_EN.
module ram_word_port
   import ram_word_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   input  logic [BYTE_W-1:0] mem_rdata
);

`ifdef RAM_WORD_PORT_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif
   // Highest legal low-byte address: the high byte at +1 must still be implemented.
   localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 2);

   state_t              state_r;
   state_t              state_n;
   logic [ADDR_W-1:0]   addr_r;
   logic [WORD_W-1:0]   wdata_r;
   logic                write_r;
   logic [BYTE_W-1:0]   lo_byte_r;
   logic                accept_s;
   logic                addr_bad_s;
   logic                cs_s;
   logic                we_s;
   logic                re_s;
   logic [ADDR_W-1:0]   maddr_s;
   logic [BYTE_W-1:0]   mwdata_s;

   assign accept_s   = req_valid & req_ready;
   assign addr_bad_s = ADDR_CHECK && (32'(req_addr) > LAST_ADDR);

   // Next-state selection.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (addr_bad_s) state_n = ST_RESP;
               else            state_n = ST_LO;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_LO:   state_n = ST_HI;
         ST_HI: begin
            if (write_r) state_n = ST_RESP;
            else         state_n = ST_CAP;
         end
         ST_CAP:  state_n = ST_RESP;
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // RAM strobes for the state being entered; LO is only entered from IDLE, so it uses the live request.
   always_comb begin
      cs_s     = 1'b0;
      we_s     = 1'b0;
      re_s     = 1'b0;
      maddr_s  = '0;
      mwdata_s = '0;
      case (state_n)
         ST_LO: begin
            cs_s    = 1'b1;
            maddr_s = req_addr;
            if (req_write) begin
               we_s     = 1'b1;
               mwdata_s = req_wdata[BYTE_W-1:0];
            end else begin
               re_s     = 1'b1;
            end
         end
         ST_HI: begin
            cs_s    = 1'b1;
            maddr_s = addr_r + ADDR_W'(1'b1);
            if (write_r) begin
               we_s     = 1'b1;
               mwdata_s = wdata_r[WORD_W-1:BYTE_W];
            end else begin
               re_s     = 1'b1;
            end
         end
         default: begin
            cs_s     = 1'b0;
            we_s     = 1'b0;
            re_s     = 1'b0;
         end
      endcase
   end

   // State, request capture, read assembly and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         addr_r    <= '0;
         wdata_r   <= '0;
         write_r   <= 1'b0;
         lo_byte_r <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_r   <= state_n;
         req_ready <= (state_n == ST_IDLE);
         rsp_valid <= (state_n == ST_RESP);
         mem_cs    <= cs_s;
         mem_we    <= we_s;
         mem_re    <= re_s;
         mem_addr  <= maddr_s;
         mem_wdata <= mwdata_s;
         if (accept_s) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            write_r <= req_write;
         end
         // The RAM returns mem[A] during HI and mem[A+1] during CAP.
         if (state_r == ST_HI) lo_byte_r <= mem_rdata;
         if (state_n == ST_RESP) begin
            rsp_err <= ADDR_CHECK && (state_r == ST_IDLE);
            if (state_r == ST_CAP) rsp_rdata <= {mem_rdata, lo_byte_r};
            else                   rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_word_port.sv
// Self-checking bench for ram_word_port: a byte RAM model on the memory side and a word-level reference memory.
module tb_ram_word_port;

`ifdef RAM_WORD_PORT_ADDR_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_cs;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;

   bit [7:0] ram     [0:65535];
   bit [7:0] ref_mem [0:65535];
   int n_vec = 0;
   int n_err = 0;

   ram_word_port #(.ADDR_W(16), .MEM_DEPTH(10000)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_cs && mem_re) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_bad(input logic [15:0] a);
      return CHECK && (a > 16'd9998);
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"},  32'(req_ready), 32'd0);
      chk({tag, "_rspv"},   32'(rsp_valid), 32'd0);
      chk({tag, "_rdata"},  32'(rsp_rdata), 32'd0);
      chk({tag, "_err"},    32'(rsp_err),   32'd0);
      chk({tag, "_strobe"}, 32'({mem_cs, mem_we, mem_re}), 32'd0);
      chk({tag, "_maddr"},  32'(mem_addr),  32'd0);
      chk({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
   endtask

   // One word transaction from accept to response, checked against the reference memory.
   task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
      int          n;
      int          cyc;
      bit          cs_seen;
      bit          both_seen;
      bit          err;
      int          exp_lat;
      logic [15:0] a1;
      logic [15:0] exp_word;
      a1       = a + 16'd1;
      err      = addr_bad(a);
      exp_lat  = err ? 1 : (w ? 3 : 4);
      exp_word = (w || err) ? 16'h0000 : {ref_mem[a1], ref_mem[a]};
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      cyc = 1; cs_seen = 1'b0; both_seen = 1'b0;
      while (1) begin
         if (mem_cs) cs_seen = 1'b1;
         if (mem_we && mem_re) both_seen = 1'b1;
         if (cyc == 1 && !err) begin
            chk("lo_addr", 32'(mem_addr), 32'(a));
            chk("lo_we", 32'({mem_we, mem_re}), w ? 32'd2 : 32'd1);
            if (w) chk("lo_wdata", 32'(mem_wdata), 32'(d[7:0]));
         end
         if (cyc == 2 && !err) begin
            chk("hi_addr", 32'(mem_addr), 32'(a1));
            if (w) chk("hi_wdata", 32'(mem_wdata), 32'(d[15:8]));
         end
         if (rsp_valid || cyc >= 8) break;
         @(negedge clk);
         cyc++;
      end
      chk("rsp_latency", 32'(cyc), 32'(exp_lat));
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_word));
      chk("rsp_err", 32'(rsp_err), 32'(err));
      chk("cs_seen", 32'(cs_seen), 32'(!err));
      chk("we_re_excl", 32'(both_seen), 32'd0);
      @(negedge clk);
      chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
      chk("rsp_hold", 32'(rsp_rdata), 32'(exp_word));
      if (w && !err) begin
         ref_mem[a]  = d[7:0];
         ref_mem[a1] = d[15:8];
      end
   endtask

   initial begin
      int          acc;
      int          np;
      int          nready;
      int          pulses [3];
      int          diffs;
      logic [15:0] a;

      // Reset
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      // Directed: write then read back a word
      do_req(1'b1, 16'h0010, 16'hBEEF);
      chk("ram_10", 32'(ram[16'h0010]), 32'h00EF);
      chk("ram_11", 32'(ram[16'h0011]), 32'h00BE);
      do_req(1'b0, 16'h0010, 16'h0000);

`ifdef RAM_WORD_PORT_ADDR_CHECK_EN
      do_req(1'b0, 16'd9999, 16'h0000);
      do_req(1'b1, 16'd9999, 16'h5A5A);
      do_req(1'b1, 16'd9998, 16'hC3D2);
      do_req(1'b0, 16'd9998, 16'h0000);
`else
      do_req(1'b1, 16'hFFFF, 16'h1234);
      chk("ram_ffff", 32'(ram[16'hFFFF]), 32'h0034);
      chk("ram_0000", 32'(ram[16'h0000]), 32'h0012);
      do_req(1'b0, 16'hFFFF, 16'h0000);
`endif

      // Three back-to-back reads with req_valid held high
      a = 16'h0010;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      acc = 0; np = 0; nready = 0;
      for (int c = 0; c < 16; c++) begin
         if (acc == 3) req_valid = 1'b0;
         if (rsp_valid) begin
            if (np < 3) pulses[np] = c;
            np++;
            chk("b2b_rdata", 32'(rsp_rdata), 32'({ref_mem[a + 16'd1], ref_mem[a]}));
         end
         if (req_ready) begin
            nready++;
            if (req_valid) acc++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_pulses", 32'(np), 32'd3);
      chk("b2b_ready_cycles", 32'(nready), 32'd4);
      chk("b2b_first", 32'(pulses[0]), 32'd4);
      chk("b2b_gap1", 32'(pulses[1] - pulses[0]), 32'd5);
      chk("b2b_gap2", 32'(pulses[2] - pulses[1]), 32'd5);

      // Reset after the low byte of a write has gone out
      do_req(1'b1, 16'h0020, 16'h1111);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAA55;
      acc = 0;
      while (!req_ready && acc < 20) begin @(negedge clk); acc++; end
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      ref_mem[16'h0020] = 8'h55;
      np = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (rsp_valid) np++;
         chk_reset("abort");
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) np++;
      end
      chk("abort_no_rsp", 32'(np), 32'd0);
      chk("abort_ram_20", 32'(ram[16'h0020]), 32'h0055);
      chk("abort_ram_21", 32'(ram[16'h0021]), 32'h0011);
      do_req(1'b0, 16'h0020, 16'h0000);

      // Randomised mix against the reference memory
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 7) a = 16'($urandom);
         else            a = 16'h0100 + 16'($urandom_range(0, 31));
         do_req(1'($urandom_range(0, 1)), a, 16'($urandom));
      end

      diffs = 0;
      for (int i = 0; i < 65536; i++) if (ram[i] != ref_mem[i]) diffs++;
      chk("ram_image", 32'(diffs), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
